// File: rtl/axi_rd_arbiter_rr_pkg.sv
// Shared AXI read-side types and the arbiter's one-hot state encoding.
package axi_rd_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam int unsigned ARB_STATE_W = 3;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 3'b001,
        ARB_AR   = 3'b010,
        ARB_R    = 3'b100
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping past the top slot.
module axi_rd_arbiter_rr_pick #(
    parameter int unsigned NR_MST = 2,
    parameter int unsigned PTR_W  = (NR_MST > 1) ? $clog2(NR_MST) : 1
) (
    input  logic [NR_MST-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  winner,
    output logic              any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NR_MST; i++) begin
            cand = PTR_W'((32'(ptr) + i) % NR_MST);
            if (!any && req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter_rr.sv
// N-to-1 AXI read-channel arbiter; round-robin grant held from AR issue until the R last beat.
module axi_rd_arbiter_rr
    import axi_rd_arbiter_rr_pkg::*;
#(
    parameter  int unsigned NR_MST = 2,
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned LEN_W  = 8,
    localparam int unsigned PTR_W  = (NR_MST > 1) ? $clog2(NR_MST) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [NR_MST-1:0]        slv_ar_valid_i,
    input  logic [NR_MST*ADDR_W-1:0] slv_ar_addr_i,
    input  logic [NR_MST*LEN_W-1:0]  slv_ar_len_i,
    output logic [NR_MST-1:0]        slv_ar_ready_o,
    output logic [NR_MST-1:0]        slv_r_valid_o,
    output logic [DATA_W-1:0]        slv_r_data_o,
    output axi_resp_t                slv_r_resp_o,
    output logic                     slv_r_last_o,
    input  logic [NR_MST-1:0]        slv_r_ready_i,

    output logic                     mst_ar_valid_o,
    output logic [ADDR_W-1:0]        mst_ar_addr_o,
    output logic [LEN_W-1:0]         mst_ar_len_o,
    input  logic                     mst_ar_ready_i,
    input  logic                     mst_r_valid_i,
    input  logic [DATA_W-1:0]        mst_r_data_i,
    input  axi_resp_t                mst_r_resp_i,
    input  logic                     mst_r_last_i,
    output logic                     mst_r_ready_o,

    output logic [PTR_W-1:0]         grant_o,
    output logic                     busy_o
);

    arb_state_e       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_q;
    logic [PTR_W-1:0] winner;
    logic             any_req;
    logic             ar_hs;
    logic             r_last_hs;

    axi_rd_arbiter_rr_pick #(
        .NR_MST (NR_MST),
        .PTR_W  (PTR_W)
    ) u_rr_pick (
        .req    (slv_ar_valid_i),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Handshake routing is a pure decode of the locked grant, so reset silences it at once.
    always_comb begin
        slv_ar_ready_o = '0;
        slv_r_valid_o  = '0;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        case (state)
            ARB_AR: begin
                mst_ar_valid_o          = slv_ar_valid_i[grant_q];
                slv_ar_ready_o[grant_q] = mst_ar_ready_i;
            end
            ARB_R: begin
                slv_r_valid_o[grant_q] = mst_r_valid_i;
                mst_r_ready_o          = slv_r_ready_i[grant_q];
            end
            default: ;
        endcase
    end

    assign mst_ar_addr_o = slv_ar_addr_i[32'(grant_q)*ADDR_W +: ADDR_W];
    assign mst_ar_len_o  = slv_ar_len_i[32'(grant_q)*LEN_W +: LEN_W];
    assign slv_r_data_o  = mst_r_data_i;
    assign slv_r_resp_o  = mst_r_resp_i;
    assign slv_r_last_o  = mst_r_last_i;
    assign grant_o       = grant_q;
    assign busy_o        = (state != ARB_IDLE);

    assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
    assign r_last_hs = mst_r_valid_i & mst_r_ready_o & mst_r_last_i;

    // Arbitrate only from IDLE; the pointer moves past the winner once its burst retires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        state   <= ARB_AR;
                    end
                end
                ARB_AR: begin
                    if (ar_hs) begin
                        state <= ARB_R;
                    end
                end
                ARB_R: begin
                    if (r_last_hs) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= (grant_q == PTR_W'(NR_MST - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_rr.sv
// Directed bench for axi_rd_arbiter_rr: a 2-master instance and a 3-master instance.
module tb_axi_rd_arbiter_rr;
    import axi_rd_arbiter_rr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 2-master instance
    logic [1:0]  a_ar_valid, a_ar_ready, a_r_valid, a_r_ready;
    logic [63:0] a_ar_addr;
    logic [15:0] a_ar_len;
    logic [31:0] a_r_data, a_m_ar_addr, a_m_r_data;
    axi_resp_t   a_r_resp, a_m_r_resp;
    logic        a_r_last, a_m_ar_valid, a_m_ar_ready, a_m_r_valid, a_m_r_last, a_m_r_ready;
    logic [7:0]  a_m_ar_len;
    logic [0:0]  a_grant;
    logic        a_busy;

    // 3-master instance
    logic [2:0]  b_ar_valid, b_ar_ready, b_r_valid, b_r_ready;
    logic [95:0] b_ar_addr;
    logic [23:0] b_ar_len;
    logic [31:0] b_r_data, b_m_ar_addr, b_m_r_data;
    axi_resp_t   b_r_resp, b_m_r_resp;
    logic        b_r_last, b_m_ar_valid, b_m_ar_ready, b_m_r_valid, b_m_r_last, b_m_r_ready;
    logic [7:0]  b_m_ar_len;
    logic [1:0]  b_grant;
    logic        b_busy;

    axi_rd_arbiter_rr #(.NR_MST(2), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .slv_ar_valid_i(a_ar_valid), .slv_ar_addr_i(a_ar_addr), .slv_ar_len_i(a_ar_len),
        .slv_ar_ready_o(a_ar_ready), .slv_r_valid_o(a_r_valid), .slv_r_data_o(a_r_data),
        .slv_r_resp_o(a_r_resp), .slv_r_last_o(a_r_last), .slv_r_ready_i(a_r_ready),
        .mst_ar_valid_o(a_m_ar_valid), .mst_ar_addr_o(a_m_ar_addr), .mst_ar_len_o(a_m_ar_len),
        .mst_ar_ready_i(a_m_ar_ready), .mst_r_valid_i(a_m_r_valid), .mst_r_data_i(a_m_r_data),
        .mst_r_resp_i(a_m_r_resp), .mst_r_last_i(a_m_r_last), .mst_r_ready_o(a_m_r_ready),
        .grant_o(a_grant), .busy_o(a_busy)
    );

    axi_rd_arbiter_rr #(.NR_MST(3), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .slv_ar_valid_i(b_ar_valid), .slv_ar_addr_i(b_ar_addr), .slv_ar_len_i(b_ar_len),
        .slv_ar_ready_o(b_ar_ready), .slv_r_valid_o(b_r_valid), .slv_r_data_o(b_r_data),
        .slv_r_resp_o(b_r_resp), .slv_r_last_o(b_r_last), .slv_r_ready_i(b_r_ready),
        .mst_ar_valid_o(b_m_ar_valid), .mst_ar_addr_o(b_m_ar_addr), .mst_ar_len_o(b_m_ar_len),
        .mst_ar_ready_i(b_m_ar_ready), .mst_r_valid_i(b_m_r_valid), .mst_r_data_i(b_m_r_data),
        .mst_r_resp_i(b_m_r_resp), .mst_r_last_i(b_m_r_last), .mst_r_ready_o(b_m_r_ready),
        .grant_o(b_grant), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-beat transaction on the 2-master instance, expecting master m to be granted.
    task automatic txn_a(input int m, input logic [31:0] addr, input logic [31:0] data);
        a_ar_valid[m]            = 1'b1;
        a_ar_addr[m*32 +: 32]    = addr;
        a_ar_len[m*8 +: 8]       = 8'd0;
        a_m_ar_ready             = 1'b1;
        @(negedge clk);
        chk("txn_grant", 64'(a_grant), 64'(m));
        @(negedge clk);
        a_ar_valid[m] = 1'b0;
        a_m_ar_ready  = 1'b0;
        a_m_r_valid   = 1'b1;
        a_m_r_data    = data;
        a_m_r_last    = 1'b1;
        a_r_ready     = 2'b11;
        #1 chk("txn_r_data", 64'(a_r_data), 64'(data));
        @(negedge clk);
        a_m_r_valid = 1'b0;
        a_m_r_last  = 1'b0;
        chk("txn_busy_done", 64'(a_busy), 64'd0);
    endtask

    logic [31:0] rx[$];
    int          sent, stall, cyc, n;
    logic        exp_rdy;

    initial begin
        rst = 1'b1;
        a_ar_valid = '0; a_ar_addr = '0; a_ar_len = '0; a_r_ready = '0;
        a_m_ar_ready = 1'b0; a_m_r_valid = 1'b0; a_m_r_data = '0; a_m_r_last = 1'b0;
        a_m_r_resp = AXI_RESP_OKAY;
        b_ar_valid = '0; b_ar_addr = '0; b_ar_len = '0; b_r_ready = '0;
        b_m_ar_ready = 1'b0; b_m_r_valid = 1'b0; b_m_r_data = '0; b_m_r_last = 1'b0;
        b_m_r_resp = AXI_RESP_OKAY;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_grant", 64'(a_grant), 64'd0);
        chk("rst_ar_ready", 64'(a_ar_ready), 64'd0);
        chk("rst_r_valid", 64'(a_r_valid), 64'd0);
        chk("rst_m_ar_valid", 64'(a_m_ar_valid), 64'd0);
        chk("rst_m_r_ready", 64'(a_m_r_ready), 64'd0);
        chk("rst3_busy", 64'(b_busy), 64'd0);

        // Three masters requesting continuously, single-beat each: grants rotate 0,1,2,0,1,2
        b_ar_valid = 3'b111;
        b_ar_addr  = {32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        b_m_ar_ready = 1'b1; b_m_r_valid = 1'b1; b_m_r_last = 1'b1; b_r_ready = 3'b111;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (b_m_ar_valid && b_m_ar_ready) begin
                chk("rr3_grant", 64'(b_grant), 64'(n % 3));
                chk("rr3_addr", 64'(b_m_ar_addr), 64'((n % 3) * 32'h100));
                n++;
            end
        end
        chk("rr3_txn_count", 64'(n), 64'd6);
        b_ar_valid = '0; b_m_ar_ready = 1'b0; b_m_r_valid = 1'b0; b_m_r_last = 1'b0; b_r_ready = '0;

        // Lone request from master1, single beat
        a_ar_valid = 2'b10;
        a_ar_addr[63:32] = 32'h8000_0000;
        #1 chk("t1_no_ar_same_cycle", 64'(a_m_ar_valid), 64'd0);
        @(negedge clk);
        chk("t1_ar_valid", 64'(a_m_ar_valid), 64'd1);
        chk("t1_grant", 64'(a_grant), 64'd1);
        chk("t1_addr", 64'(a_m_ar_addr), 64'h8000_0000);
        chk("t1_len", 64'(a_m_ar_len), 64'd0);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_ar_ready_wait", 64'(a_ar_ready), 64'd0);
        a_m_ar_ready = 1'b1;
        #1 chk("t1_ar_ready", 64'(a_ar_ready), 64'b10);
        @(negedge clk);
        chk("t1_r_no_ar_valid", 64'(a_m_ar_valid), 64'd0);
        a_ar_valid = 2'b00; a_m_ar_ready = 1'b0;
        a_m_r_valid = 1'b1; a_m_r_data = 32'hDEAD_BEEF; a_m_r_last = 1'b1;
        a_m_r_resp = AXI_RESP_SLVERR; a_r_ready = 2'b11;
        #1;
        chk("t1_r_valid", 64'(a_r_valid), 64'b10);
        chk("t1_m_r_ready", 64'(a_m_r_ready), 64'd1);
        chk("t1_r_data", 64'(a_r_data), 64'hDEAD_BEEF);
        chk("t1_r_resp", 64'(a_r_resp), 64'(AXI_RESP_SLVERR));
        chk("t1_r_last", 64'(a_r_last), 64'd1);
        @(negedge clk);
        chk("t1_busy_fall", 64'(a_busy), 64'd0);
        chk("t1_rr_ptr", 64'(u_dut2.rr_ptr), 64'd0);
        // Stray R valid still asserted while IDLE
        chk("stray_m_r_ready", 64'(a_m_r_ready), 64'd0);
        chk("stray_r_valid", 64'(a_r_valid), 64'd0);
        @(negedge clk);
        chk("stray_still_idle", 64'(a_busy), 64'd0);
        a_m_r_valid = 1'b0; a_m_r_last = 1'b0; a_m_r_resp = AXI_RESP_OKAY; a_r_ready = 2'b00;

        // Burst len=3 from master0 while master1 waits
        a_ar_valid = 2'b11;
        a_ar_addr  = {32'h0000_2000, 32'h0000_1000};
        a_ar_len   = {8'd2, 8'd3};
        @(negedge clk);
        chk("t3_grant0", 64'(a_grant), 64'd0);
        chk("t3_len", 64'(a_m_ar_len), 64'd3);
        chk("t3_addr", 64'(a_m_ar_addr), 64'h1000);
        a_m_ar_ready = 1'b1;
        #1 chk("t3_ar_ready0", 64'(a_ar_ready), 64'b01);
        @(negedge clk);
        a_ar_valid = 2'b10; a_m_ar_ready = 1'b0; a_r_ready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            a_m_r_valid = 1'b1;
            a_m_r_data  = 32'hB000 + 32'(b);
            a_m_r_last  = (b == 3);
            #1;
            chk("t3_m1_ar_ready_held", 64'(a_ar_ready), 64'd0);
            chk("t3_r_valid", 64'(a_r_valid), 64'b01);
            @(negedge clk);
        end
        chk("t3_idle_after_last", 64'(a_busy), 64'd0);
        a_m_r_valid = 1'b0; a_m_r_last = 1'b0;
        @(negedge clk);
        chk("t3_grant1_next", 64'(a_grant), 64'd1);
        chk("t3_m1_addr", 64'(a_m_ar_addr), 64'h2000);

        // AR back-pressure for 5 cycles, then R back-pressure on the second beat
        for (int i = 0; i < 5; i++) begin
            chk("t4_ar_valid_hold", 64'(a_m_ar_valid), 64'd1);
            chk("t4_addr_stable", 64'(a_m_ar_addr), 64'h2000);
            chk("t4_len_stable", 64'(a_m_ar_len), 64'd2);
            chk("t4_no_ar_ready", 64'(a_ar_ready), 64'd0);
            @(negedge clk);
        end
        a_m_ar_ready = 1'b1;
        #1 chk("t4_ar_ready1", 64'(a_ar_ready), 64'b10);
        @(negedge clk);
        a_ar_valid = 2'b00; a_m_ar_ready = 1'b0;
        sent = 0; stall = 2; cyc = 0;
        while (sent < 3 && cyc < 20) begin
            exp_rdy     = !(sent == 1 && stall > 0);
            a_m_r_valid = 1'b1;
            a_m_r_data  = 32'hC000 + 32'(sent);
            a_m_r_last  = (sent == 2);
            a_r_ready   = {exp_rdy, 1'b1};
            #1;
            chk("t4_m_r_ready_follows", 64'(a_m_r_ready), 64'(exp_rdy));
            if (a_r_valid[1] && a_r_ready[1]) rx.push_back(a_r_data);
            if (a_m_r_ready) sent++;
            else stall--;
            cyc++;
            @(negedge clk);
        end
        chk("t4_beats_sent", 64'(sent), 64'd3);
        chk("t4_beats_recv", 64'(rx.size()), 64'd3);
        for (int i = 0; i < rx.size(); i++) chk("t4_beat_data", 64'(rx[i]), 64'(32'hC000 + 32'(i)));
        chk("t4_idle", 64'(a_busy), 64'd0);
        a_m_r_valid = 1'b0; a_m_r_last = 1'b0; a_r_ready = 2'b00;

        // Async reset mid-burst (pointer first moved to 1 by a master0 transaction)
        txn_a(0, 32'h4000, 32'h1111);
        chk("t5_ptr_before", 64'(u_dut2.rr_ptr), 64'd1);
        a_ar_valid = 2'b10; a_ar_addr[63:32] = 32'h5000; a_ar_len[15:8] = 8'd3; a_m_ar_ready = 1'b1;
        @(negedge clk);
        chk("t5_grant1", 64'(a_grant), 64'd1);
        @(negedge clk);
        a_ar_valid = 2'b00; a_m_ar_ready = 1'b0;
        a_m_r_valid = 1'b1; a_m_r_last = 1'b0; a_r_ready = 2'b10;
        #1 chk("t5_r_valid_pre", 64'(a_r_valid), 64'b10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_r_valid", 64'(a_r_valid), 64'd0);
        chk("t5_rst_m_r_ready", 64'(a_m_r_ready), 64'd0);
        chk("t5_rst_busy", 64'(a_busy), 64'd0);
        chk("t5_rst_grant", 64'(a_grant), 64'd0);
        chk("t5_rst_ptr", 64'(u_dut2.rr_ptr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        a_m_r_valid = 1'b0; a_r_ready = 2'b00;
        a_ar_valid = 2'b10; a_ar_addr[63:32] = 32'h6000; a_ar_len[15:8] = 8'd0;
        @(negedge clk);
        chk("t5_post_grant", 64'(a_grant), 64'd1);
        chk("t5_post_ar_valid", 64'(a_m_ar_valid), 64'd1);
        chk("t5_post_addr", 64'(a_m_ar_addr), 64'h6000);
        a_m_ar_ready = 1'b1;
        @(negedge clk);
        a_ar_valid = 2'b00; a_m_ar_ready = 1'b0;
        a_m_r_valid = 1'b1; a_m_r_last = 1'b1; a_m_r_data = 32'h7777; a_r_ready = 2'b10;
        #1 chk("t5_post_r_valid", 64'(a_r_valid), 64'b10);
        @(negedge clk);
        chk("t5_post_done", 64'(a_busy), 64'd0);
        a_m_r_valid = 1'b0; a_m_r_last = 1'b0; a_r_ready = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
